// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM type and default taps/seed for the LFSR generator
package lfsr_pkg;
  typedef enum logic {WARM, RUN} lfsr_fsm_e;
  localparam logic [31:0] LFSR_DEF_TAPS = 32'h088C8892;
  localparam logic [31:0] LFSR_DEF_SEED = 32'd12242877;
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: STEPS-fold unrolled Fibonacci LFSR next-state function
module lfsr_step import lfsr_pkg::*; #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_DEF_TAPS),
  parameter int STEPS = 1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);
  logic [WIDTH-1:0] s;
  always_comb begin
    s = state_i;
    for (int k = 0; k < STEPS; k++) s = {s[WIDTH-2:0], ^(s & TAPS)};
    state_o = s;
  end
endmodule

// File: rtl/lfsr_prng.sv
// lfsr_prng: Fibonacci LFSR generator with reseed, warm-up and valid/ready output.
// Define LFSR_LOCKUP_RECOVER_EN to reload SEED (and pulse lockup_o) on an all-zero state.
module lfsr_prng import lfsr_pkg::*; #(
  parameter int WIDTH = 32,
  parameter logic [63:0] TAPS = 64'(LFSR_DEF_TAPS),
  parameter logic [63:0] SEED = 64'(LFSR_DEF_SEED),
  parameter int STEPS = 1,
  parameter int OUT_W = 32,
  parameter int WARMUP = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [OUT_W-1:0] rnd_o,
  output logic             rnd_valid_o,
  input  logic             rnd_ready_i,
  output logic             busy_o,
  output logic             lockup_o
);
  localparam logic [WIDTH-1:0] TAP_M = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
  localparam logic [7:0] WARM_N = 8'(WARMUP);
  localparam lfsr_fsm_e FSM_INIT = (WARMUP > 0) ? WARM : RUN;

  logic [WIDTH-1:0] state_q, state_d, adv;
  lfsr_fsm_e        fsm_q, fsm_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0] rnd_q, rnd_d;
  logic             vld_q, vld_d, lock_q, lock_d;

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAP_M), .STEPS(STEPS)) u_step (
    .state_i(state_q),
    .state_o(adv)
  );

  always_comb begin
    state_d = state_q;
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    vld_d   = vld_q;
    lock_d  = 1'b0;
    if (seed_load_i) begin
      state_d = seed_i;
      cnt_d   = WARM_N;
      vld_d   = 1'b0;
      fsm_d   = FSM_INIT;
    end else if (fsm_q == WARM) begin
      if (en_i) begin
        state_d = adv;
        cnt_d   = cnt_q - 8'd1;
        fsm_d   = (cnt_q == 8'd1) ? RUN : WARM;
      end
    end else if (!vld_q || rnd_ready_i) begin
      // output slot free or being drained this cycle
      state_d = en_i ? adv : state_q;
      rnd_d   = en_i ? adv[OUT_W-1:0] : rnd_q;
      vld_d   = en_i;
    end
`ifdef LFSR_LOCKUP_RECOVER_EN
    if (state_d == '0) begin
      state_d = SEED_W;
      cnt_d   = WARM_N;
      vld_d   = 1'b0;
      fsm_d   = FSM_INIT;
      lock_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= SEED_W;
      fsm_q   <= FSM_INIT;
      cnt_q   <= WARM_N;
      rnd_q   <= '0;
      vld_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      vld_q   <= vld_d;
      lock_q  <= lock_d;
    end
  end

  assign rnd_o       = rnd_q;
  assign rnd_valid_o = vld_q;
  assign busy_o      = (fsm_q == WARM);
  assign lockup_o    = lock_q;
endmodule

// File: tb/tb_lfsr_prng.sv
// tb_lfsr_prng: scoreboard bench for lfsr_prng; words predicted from the LFSR rule, checked on each handshake
module tb_lfsr_prng;
  localparam logic [31:0] TAPS = 32'h088C8892;
  localparam logic [31:0] SEED = 32'd1;
`ifdef LFSR_LOCKUP_RECOVER_EN
  localparam logic [31:0] RECOVER = 32'd1;
`else
  localparam logic [31:0] RECOVER = 32'd0;
`endif

  logic clk_i = 1'b0, reset_i = 1'b0, en_i = 1'b0, seed_load_i = 1'b0, rnd_ready_i = 1'b0;
  logic [31:0] seed_i = '0;
  logic [31:0] rnd_o, w_rnd;
  logic rnd_valid_o, busy_o, lockup_o, w_valid, w_busy, w_lock;
  logic w_ld = 1'b0;
  logic [31:0] w_seed = '0;

  typedef struct { logic [31:0] word; int ep; } exp_t;
  exp_t q[$];
  int s_ep = 0, mon_ep = 0, n_chk = 0, n_fail = 0, n_pop = 0;
  logic [31:0] m_state = SEED;
  logic [31:0] basic [4] = '{32'h2, 32'h5, 32'hA, 32'h15};

  always #5 clk_i = ~clk_i;

  lfsr_prng #(.WIDTH(32), .TAPS(64'h088C8892), .SEED(64'd1), .STEPS(1), .OUT_W(32), .WARMUP(0)) u_dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .seed_load_i(seed_load_i), .seed_i(seed_i),
    .rnd_o(rnd_o), .rnd_valid_o(rnd_valid_o), .rnd_ready_i(rnd_ready_i), .busy_o(busy_o), .lockup_o(lockup_o)
  );

  lfsr_prng #(.WIDTH(32), .TAPS(64'h088C8892), .SEED(64'd1), .STEPS(1), .OUT_W(32), .WARMUP(3)) u_warm (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .seed_load_i(w_ld), .seed_i(w_seed),
    .rnd_o(w_rnd), .rnd_valid_o(w_valid), .rnd_ready_i(rnd_ready_i), .busy_o(w_busy), .lockup_o(w_lock)
  );

  // shift left by one, new LSB is the parity of the tapped bits
  function automatic logic [31:0] nxt(logic [31:0] s);
    return (s << 1) | 32'($countones(s & TAPS) % 2);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic topup();
    int n = 0;
    logic [31:0] w;
    foreach (q[i]) if (q[i].ep == s_ep) n++;
    while (n < 8) begin
      w = nxt(m_state);
      if (RECOVER != 0 && w == 0) m_state = SEED;
      else begin
        m_state = w;
        q.push_back('{w, s_ep});
        n++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    topup();
  endtask

  task automatic reseed(logic [31:0] s);
    seed_i = s;
    seed_load_i = 1'b1;
    s_ep++;
    m_state = (RECOVER != 0 && s == 0) ? SEED : s;
    topup();
  endtask

  task automatic hit_reset();
    reset_i = 1'b1;
    s_ep++;
    m_state = SEED;
    topup();
  endtask

  logic stall_q = 1'b0, in_rst = 1'b0;
  logic [31:0] held = '0;
  always @(negedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      if (!in_rst) mon_ep++;
      in_rst = 1'b1;
      stall_q = 1'b0;
    end else begin
      in_rst = 1'b0;
      if (stall_q) begin
        chk("hold_valid", 32'(rnd_valid_o), 32'd1);
        chk("hold_word", rnd_o, held);
      end
      if (rnd_valid_o && rnd_ready_i) begin
        while (q.size() > 0 && q[0].ep < mon_ep) void'(q.pop_front());
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_empty: got word %0h with no expected word", rnd_o);
        end else begin
          chk("sb_word", rnd_o, q[0].word);
          void'(q.pop_front());
          n_pop++;
        end
      end
      stall_q = rnd_valid_o && !rnd_ready_i && !seed_load_i;
      held = rnd_o;
      if (seed_load_i) mon_ep++;
    end
  end

  initial begin
    #1;
    rnd_ready_i = 1'b1;
    hit_reset();
    tick();
    tick();
    chk("rst_valid", 32'(rnd_valid_o), 32'd0);
    chk("rst_word", rnd_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_lock", 32'(lockup_o), 32'd0);
    chk("warm_rst_busy", 32'(w_busy), 32'd1);
    chk("warm_rst_valid", 32'(w_valid), 32'd0);
    reset_i = 1'b0;
    en_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("basic_valid", 32'(rnd_valid_o), 32'd1);
      chk("basic_word", rnd_o, basic[i-1]);
      chk("warm_busy", 32'(w_busy), (i < 3) ? 32'd1 : 32'd0);
      chk("warm_valid", 32'(w_valid), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("warm_first", w_rnd, 32'h15);
    tick();
    reseed(32'd1);
    tick();
    seed_load_i = 1'b0;
    chk("reseed_drop", 32'(rnd_valid_o), 32'd0);
    tick();
    chk("reseed_word", rnd_o, 32'h2);
    rnd_ready_i = 1'b0;
    repeat (3) begin
      tick();
      chk("bp_valid", 32'(rnd_valid_o), 32'd1);
      chk("bp_word", rnd_o, 32'h2);
    end
    rnd_ready_i = 1'b1;
    tick();
    chk("bp_next", rnd_o, 32'h5);
    tick();
    chk("bp_after", rnd_o, 32'hA);
    reseed(32'd0);
    tick();
    seed_load_i = 1'b0;
    chk("lock_pulse", 32'(lockup_o), RECOVER);
    chk("lock_valid", 32'(rnd_valid_o), 32'd0);
    tick();
    chk("lock_clear", 32'(lockup_o), 32'd0);
    chk("lock_word", rnd_o, (RECOVER != 0) ? 32'h2 : 32'h0);
    tick();
    chk("lock_word2", rnd_o, (RECOVER != 0) ? 32'h5 : 32'h0);
    reseed(32'd1);
    tick();
    seed_load_i = 1'b0;
    tick();
    rnd_ready_i = 1'b0;
    tick();
    chk("stall_valid", 32'(rnd_valid_o), 32'd1);
    #2;
    hit_reset();
    #1;
    chk("async_clear", 32'(rnd_valid_o), 32'd0);
    tick();
    tick();
    reset_i = 1'b0;
    rnd_ready_i = 1'b1;
    tick();
    chk("restart_word", rnd_o, 32'h2);
    tick();
    chk("restart_word2", rnd_o, 32'h5);
    repeat (3000) begin
      en_i = ($urandom % 4) != 0;
      rnd_ready_i = ($urandom % 10) < 7;
      if ($urandom % 40 == 0) reseed(($urandom % 8 == 0) ? 32'd0 : 32'($urandom));
      else seed_load_i = 1'b0;
      tick();
    end
    seed_load_i = 1'b0;
    en_i = 1'b0;
    rnd_ready_i = 1'b1;
    tick();
    tick();
    chk("handshakes", 32'(n_pop > 500), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lfsr_prng.md
Name: lfsr_prng

Overview:
- Parametrised Fibonacci LFSR pseudo-random generator; next generation of the fixed 32-bit free-running LFSR.
- Configurable width, tap mask and seed, plus steps per cycle (unrolled).
- Adds runtime reseed, enable, a post-seed warm-up phase and a valid/ready output stream with back-pressure.
- Feeds test-pattern, dither and scrambler consumers.

Parameters:
- WIDTH, 32: LFSR state width, 8..64.
- TAPS, 32'h088C8892: feedback tap mask. Bit k set means state[k] is XORed into the feedback. Default equals taps 27,23,19,18,15,11,7,4,1.
- SEED, 32'd12242877: reset and lockup-recovery seed. Must be non-zero.
- STEPS, 1: LFSR shifts per advance, 1..WIDTH.
- OUT_W, 32: output word width, <= WIDTH. The word is state[OUT_W-1:0].
- WARMUP, 0: advances discarded after reset or seed load, 0..255.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- en_i  in  1  generator enable
- seed_load_i  in  1  load seed_i this cycle
- seed_i  in  WIDTH  runtime seed
- rnd_o  out  OUT_W  random word
- rnd_valid_o  out  1  rnd_o valid
- rnd_ready_i  in  1  consumer accepts word
- busy_o  out  1  high in WARM state
- lockup_o  out  1  one-cycle pulse on zero-state detect

Behaviour:
- Single step: state_next = {state[WIDTH-2:0], ^(state & TAPS)}.
- One advance applies STEPS single steps combinationally within one cycle.
- Reset values: state=SEED, FSM=WARM if WARMUP>0 else RUN, warm counter=WARMUP, rnd_o=0, rnd_valid_o=0, busy_o=(WARMUP>0), lockup_o=0.
- FSM state WARM:
  - If en_i, advance and decrement the counter.
  - When the counter reaches 1 and advances, go to RUN.
  - rnd_valid_o is held at 0.
- FSM state RUN, when output register is empty or the held word is being accepted (rnd_valid_o && rnd_ready_i):
  - If en_i: advance; rnd_o <= state_after_advance[OUT_W-1:0]; rnd_valid_o <= 1.
  - Else: rnd_valid_o <= 0 on accept.
- FSM state RUN, when rnd_valid_o && !rnd_ready_i: stall.
  - State, rnd_o and rnd_valid_o are held.
  - rnd_o must not change while valid is high.
- Latency:
  - With WARMUP=0, the first word is valid in the first clk_i edge after reset release with en_i=1.
  - With WARMUP=N, the first word is valid at edge N+1.
- seed_load_i has priority over everything in any state:
  - state <= seed_i; counter <= WARMUP; rnd_valid_o <= 0; FSM <= WARM if WARMUP>0 else RUN.
  - A pending unaccepted word is dropped.
  - seed_load_i together with rnd_ready_i: the word counts as accepted.
- en_i low: no advance; the counter holds; a held valid word stays valid.
- Async reset mid-stream clears valid immediately and restarts from SEED.
- Width rule: all XOR reduction is over WIDTH bits; TAPS bits >= WIDTH are ignored.

Optional Feature:
- Macro: LFSR_LOCKUP_RECOVER_EN.
- Defined:
  - If the state after seed load or advance would be all-zero, state loads SEED instead and lockup_o pulses for one cycle.
  - The FSM restarts WARM/RUN exactly as for a seed load with SEED.
- Undefined:
  - A zero seed yields a stuck zero state; the generator keeps emitting 0 words.
  - lockup_o is tied 0.

Decomposition:
- Package lfsr_pkg holds:
  - typedef lfsr_fsm_e {WARM, RUN};
  - localparam default taps 32'h088C8892;
  - localparam default seed 32'd12242877.
- One natural sub-module, lfsr_step: purely combinational STEPS-fold unrolled next-state function, parameters WIDTH/TAPS/STEPS. It is reusable by scrambler blocks.

Test Plan:
- Common bench settings for all scenarios: WIDTH=32, TAPS default, STEPS=1, OUT_W=32.
- Basic sequence: SEED=1, WARMUP=0, en_i=1, rnd_ready_i=1 -> rnd_o sequence 0x2, 0x5, 0xA, 0x15, valid every cycle.
- Back-pressure: drop rnd_ready_i for 3 cycles after the first word -> rnd_o holds 0x2 with valid high; 0x5 appears the cycle after ready returns; no words skipped.
- Warm-up: WARMUP=3, SEED=1 -> busy_o high 3 cycles, valid low; first word 0x15.
- Mid-stream reseed: after 5 words, seed_load_i with seed_i=1 (WARMUP=0) -> valid drops one cycle, then 0x2, 0x5 repeat.
- Lockup: seed_i=0 with LFSR_LOCKUP_RECOVER_EN -> lockup_o single pulse, sequence restarts from SEED. Without the macro -> rnd_o=0 forever.
- Reset mid-stall: assert reset_i asynchronously while valid&&!ready -> rnd_valid_o=0 before the next edge, and the sequence restarts from SEED after release.
